sliding_window_unit: RTL and testbench

- Sits between fetch_unit and the PE array.
- Consumes the raster-order pixel stream that fetch_unit produces, swu_pixel_out/swu_pixel_valid_out.
- Buffers the last K-1 image rows in line buffers and builds a KxK window with stride 1 and valid-only convolution (no padding).
- Returns each window packed on swu_window_in/swu_window_valid_in, which fetch_unit forwards to the PE array.

---
 rtl/swu_pkg.sv | 18 +
 rtl/swu_line_buffer.sv | 23 ++
 rtl/sliding_window_unit.sv | 135 +++++++++++++
 tb/tb_sliding_window_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/swu_pkg.sv
// rtl/swu_pkg.sv - shared constants, pixel and config types for the sliding window unit
package swu_pkg;
   localparam int DEF_DATA_WIDTH        = 32;
   localparam int DEF_MAX_KERNEL_SIZE   = 5;
   localparam int DEF_KERNEL_SIZE_WIDTH = 3;
   localparam int DEF_MAX_IMG_SIZE      = 64;
   localparam int IMG_SIZE_WIDTH        = 12;
   localparam int WIN_ENTRIES           = DEF_MAX_KERNEL_SIZE * DEF_MAX_KERNEL_SIZE;

   typedef logic [DEF_DATA_WIDTH-1:0] pixel_t;

   typedef struct packed {
      logic [DEF_KERNEL_SIZE_WIDTH-1:0]   k;
      logic [IMG_SIZE_WIDTH-1:0]          n;
      logic [2*DEF_KERNEL_SIZE_WIDTH-1:0] kk;
      logic                               stride2;
   } swu_cfg_t;
endpackage

// File: rtl/swu_line_buffer.sv
// rtl/swu_line_buffer.sv - single-port read-before-write row delay RAM
// Read is combinational so the old row is available in the same cycle it is overwritten.
module swu_line_buffer
   import swu_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_MAX_IMG_SIZE,
   parameter int AW         = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  i_we,
   input  logic [AW-1:0]         i_addr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   output logic [DATA_WIDTH-1:0] o_rdata
);
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/sliding_window_unit.sv
// rtl/sliding_window_unit.sv - KxK stride-1 valid-only window builder over a raster pixel stream
// Defining SWU_STRIDE2_EN adds stride2_in, which keeps only windows with even top-left corners.
module sliding_window_unit
   import swu_pkg::*;
#(
   parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
   parameter int MAX_KERNEL_SIZE   = DEF_MAX_KERNEL_SIZE,
   parameter int KERNEL_SIZE_WIDTH = DEF_KERNEL_SIZE_WIDTH,
   parameter int MAX_IMG_SIZE      = DEF_MAX_IMG_SIZE
) (
   input  logic                                                 clk,
   input  logic                                                 rstn,
   input  logic [KERNEL_SIZE_WIDTH-1:0]                         kernel_size_in,
   input  logic [IMG_SIZE_WIDTH-1:0]                            img_size_in,
   input  logic [DATA_WIDTH-1:0]                                pixel_in,
   input  logic                                                 pixel_valid_in,
`ifdef SWU_STRIDE2_EN
   input  logic                                                 stride2_in,
`endif
   output logic [MAX_KERNEL_SIZE*MAX_KERNEL_SIZE*DATA_WIDTH-1:0] window_out,
   output logic                                                 window_valid_out,
   output logic                                                 frame_done_out,
   output logic                                                 cfg_err_out
);
   localparam int MK   = MAX_KERNEL_SIZE;
   localparam int AW   = $clog2(MAX_IMG_SIZE);
   localparam int KK_W = 2 * KERNEL_SIZE_WIDTH;
   localparam logic [KERNEL_SIZE_WIDTH-1:0] K_MAX = KERNEL_SIZE_WIDTH'(MAX_KERNEL_SIZE);
   localparam logic [IMG_SIZE_WIDTH-1:0]    N_MAX = IMG_SIZE_WIDTH'(MAX_IMG_SIZE);

   logic [IMG_SIZE_WIDTH-1:0] r_row, r_col;
   swu_cfg_t                  r_cfg, w_cfg_in, w_cfg;
   logic                      w_first, w_bad, w_last_col, w_last_row, w_emit, w_stride;
   logic [IMG_SIZE_WIDTH-1:0] w_n_eff, w_n_last, w_k_last;
   logic [DATA_WIDTH-1:0]     w_lb_rd     [MK-1];
   logic [DATA_WIDTH-1:0]     w_col       [MK];
   logic [DATA_WIDTH-1:0]     r_shift     [MK][MK];
   logic [DATA_WIDTH-1:0]     w_shift_nxt [MK][MK];
   logic [MK*MK*DATA_WIDTH-1:0] w_pack;

`ifdef SWU_STRIDE2_EN
   assign w_stride = stride2_in;
`else
   assign w_stride = 1'b0;
`endif

   // The first pixel of a frame uses the live inputs; every later pixel uses the latch.
   assign w_first        = (r_row == '0) && (r_col == '0);
   assign w_cfg_in.k       = kernel_size_in;
   assign w_cfg_in.n       = img_size_in;
   assign w_cfg_in.kk      = KK_W'(kernel_size_in) * KK_W'(kernel_size_in);
   assign w_cfg_in.stride2 = w_stride;
   assign w_cfg = w_first ? w_cfg_in : r_cfg;

   assign w_bad = (w_cfg.k == '0) || (w_cfg.k > K_MAX) || (w_cfg.n == '0) || (w_cfg.n > N_MAX);
   assign w_n_eff  = (w_cfg.n == '0) ? IMG_SIZE_WIDTH'(1) : ((w_cfg.n > N_MAX) ? N_MAX : w_cfg.n);
   assign w_n_last = w_n_eff - IMG_SIZE_WIDTH'(1);
   assign w_k_last = IMG_SIZE_WIDTH'(w_cfg.k) - IMG_SIZE_WIDTH'(1);
   assign w_last_col = (r_col == w_n_last);
   assign w_last_row = (r_row == w_n_last);

   assign w_emit = pixel_valid_in && !w_bad && (r_row >= w_k_last) && (r_col >= w_k_last) &&
                   (!w_cfg.stride2 || ((r_row[0] == w_k_last[0]) && (r_col[0] == w_k_last[0])));

   for (genvar j = 0; j < MK-1; j++) begin : g_lb
      logic [DATA_WIDTH-1:0] w_wdata;
      if (j == 0) begin : g_head
         assign w_wdata = pixel_in;
      end else begin : g_tail
         assign w_wdata = w_lb_rd[j-1];
      end
      swu_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(MAX_IMG_SIZE), .AW(AW)) u_lb (
         .clk     (clk),
         .i_we    (pixel_valid_in),
         .i_addr  (r_col[AW-1:0]),
         .i_wdata (w_wdata),
         .o_rdata (w_lb_rd[j])
      );
   end

   // Depth index a counts rows above the current pixel; column MK-1 is the newest.
   always_comb begin
      w_col[0] = pixel_in;
      for (int j = 0; j < MK-1; j++) w_col[j+1] = w_lb_rd[j];
      for (int a = 0; a < MK; a++) begin
         for (int c = 0; c < MK-1; c++) w_shift_nxt[a][c] = r_shift[a][c+1];
         w_shift_nxt[a][MK-1] = w_col[a];
      end
   end

   always_comb begin
      w_pack = '0;
      for (int kv = 1; kv <= MK; kv++) begin
         if (w_cfg.k == KERNEL_SIZE_WIDTH'(kv)) begin
            for (int r = 0; r < kv; r++) begin
               for (int c = 0; c < kv; c++) begin
                  if ((r*kv + c) < int'(w_cfg.kk))
                     w_pack[(r*kv+c)*DATA_WIDTH +: DATA_WIDTH] = w_shift_nxt[kv-1-r][MK-kv+c];
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_row            <= '0;
         r_col            <= '0;
         r_cfg            <= '0;
         window_out       <= '0;
         window_valid_out <= 1'b0;
         frame_done_out   <= 1'b0;
         cfg_err_out      <= 1'b0;
         for (int a = 0; a < MK; a++)
            for (int c = 0; c < MK; c++) r_shift[a][c] <= '0;
      end else begin
         window_valid_out <= w_emit;
         frame_done_out   <= pixel_valid_in && w_last_col && w_last_row;
         // Error stays visible through the frame_done cycle; a new bad frame re-arms it.
         if (pixel_valid_in && w_first && w_bad) cfg_err_out <= 1'b1;
         else if (frame_done_out)                cfg_err_out <= 1'b0;
         if (pixel_valid_in) begin
            if (w_first) r_cfg <= w_cfg_in;
            r_shift <= w_shift_nxt;
            if (w_emit) window_out <= w_pack;
            if (w_last_col) begin
               r_col <= '0;
               r_row <= w_last_row ? '0 : r_row + IMG_SIZE_WIDTH'(1);
            end else begin
               r_col <= r_col + IMG_SIZE_WIDTH'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_sliding_window_unit.sv
// tb/tb_sliding_window_unit.sv - self-checking bench for sliding_window_unit
module tb_sliding_window_unit;
   import swu_pkg::*;
   localparam int DW  = 32;
   localparam int MK  = 5;
   localparam int WB  = MK * MK * DW;

   logic          clk = 1'b0;
   logic          rstn;
   logic [2:0]    kernel_size_in;
   logic [11:0]   img_size_in;
   logic [DW-1:0] pixel_in;
   logic          pixel_valid_in;
`ifdef SWU_STRIDE2_EN
   logic          stride2_in;
`endif
   logic [WB-1:0] window_out;
   logic          window_valid_out, frame_done_out, cfg_err_out;

   int tests = 0;
   int fails = 0;
   logic [WB-1:0] got_q[$];
   logic [WB-1:0] exp_q[$];
   int done_cnt = 0, err_cyc = 0;
   int got_ptr = 0, done_ptr = 0, err_ptr = 0;
   pixel_t img[];

   typedef struct {
      int n;
      int k;
      int exp_windows;
      bit exp_err;
   } vec_t;
   vec_t tbl[7];

   sliding_window_unit dut (
      .clk              (clk),
      .rstn             (rstn),
      .kernel_size_in   (kernel_size_in),
      .img_size_in      (img_size_in),
      .pixel_in         (pixel_in),
      .pixel_valid_in   (pixel_valid_in),
`ifdef SWU_STRIDE2_EN
      .stride2_in       (stride2_in),
`endif
      .window_out       (window_out),
      .window_valid_out (window_valid_out),
      .frame_done_out   (frame_done_out),
      .cfg_err_out      (cfg_err_out)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (window_valid_out) got_q.push_back(window_out);
      if (frame_done_out) done_cnt++;
      if (cfg_err_out) err_cyc++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_win(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send(input logic v, input logic [DW-1:0] p);
      pixel_valid_in = v;
      pixel_in       = p;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) send(1'b0, $urandom);
   endtask

   // Window with top-left (tr,tc): element (r,c) is image pixel (tr+r, tc+c).
   function automatic logic [WB-1:0] model_win(input int n, input int k, input int tr, input int tc);
      logic [WB-1:0] w = '0;
      for (int r = 0; r < k; r++)
         for (int c = 0; c < k; c++)
            w[(r*k+c)*DW +: DW] = img[(tr+r)*n + tc + c];
      return w;
   endfunction

   task automatic push_model(input int n, input int k, input bit s2);
      if (k < 1 || k > MK || n < 1 || n > 64) return;
      for (int tr = 0; tr <= n - k; tr++)
         for (int tc = 0; tc <= n - k; tc++)
            if (!s2 || (tr % 2 == 0 && tc % 2 == 0)) exp_q.push_back(model_win(n, k, tr, tc));
   endtask

   task automatic run_frame(input int n, input int k, input bit s2, input int gap_pct, input bit mid_change);
      int nn;
      nn  = (n == 0) ? 1 : ((n > 64) ? 64 : n);
      img = new[nn*nn];
      for (int i = 0; i < nn*nn; i++) img[i] = $urandom;
      push_model(n, k, s2);
      for (int i = 0; i < nn*nn; i++) begin
         for (int g = 0; g < 5 && $urandom_range(99) < gap_pct; g++) send(1'b0, $urandom);
         if (i == 0) begin
            kernel_size_in = 3'(k);
            img_size_in    = 12'(n);
`ifdef SWU_STRIDE2_EN
            stride2_in     = s2;
`endif
         end else if (mid_change) begin
            kernel_size_in = 3'($urandom_range(1, 5));
            img_size_in    = 12'($urandom_range(1, 64));
`ifdef SWU_STRIDE2_EN
            stride2_in     = 1'($urandom);
`endif
         end
         send(1'b1, img[i]);
      end
   endtask

   task automatic verify(input string name, input int exp_cnt, input int exp_done);
      int ng;
      ng = got_q.size() - got_ptr;
      check({name, " window count"}, ng, exp_cnt);
      for (int i = 0; i < ng && i < exp_q.size(); i++)
         check_win({name, " window"}, got_q[got_ptr+i], exp_q[i]);
      got_ptr += ng;
      exp_q.delete();
      check({name, " frame_done count"}, done_cnt - done_ptr, exp_done);
      done_ptr = done_cnt;
   endtask

   initial begin
      tbl[0] = '{n: 4, k: 3, exp_windows: 4,  exp_err: 1'b0};
      tbl[1] = '{n: 4, k: 1, exp_windows: 16, exp_err: 1'b0};
      tbl[2] = '{n: 4, k: 5, exp_windows: 0,  exp_err: 1'b0};
      tbl[3] = '{n: 4, k: 6, exp_windows: 0,  exp_err: 1'b1};
      tbl[4] = '{n: 4, k: 4, exp_windows: 1,  exp_err: 1'b0};
      tbl[5] = '{n: 1, k: 1, exp_windows: 1,  exp_err: 1'b0};
      tbl[6] = '{n: 0, k: 2, exp_windows: 0,  exp_err: 1'b1};

      rstn           = 1'b0;
      kernel_size_in = '0;
      img_size_in    = '0;
      pixel_in       = '0;
      pixel_valid_in = 1'b0;
`ifdef SWU_STRIDE2_EN
      stride2_in     = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check("reset window_valid", window_valid_out, 0);
      check("reset frame_done", frame_done_out, 0);
      check("reset cfg_err", cfg_err_out, 0);
      check("reset window_out zero", window_out == '0, 1);
      rstn = 1'b1;
      idle(2);

      // N=4 K=3 with pixels 1..16: exact first/last windows and timing
      img = new[16];
      for (int i = 0; i < 16; i++) img[i] = pixel_t'(i + 1);
      push_model(4, 3, 1'b0);
      kernel_size_in = 3'd3;
      img_size_in    = 12'd4;
      for (int i = 0; i < 16; i++) begin
         send(1'b1, img[i]);
         if (i == 9) check("n4k3 no window before pixel 11", window_valid_out, 0);
         if (i == 10) begin
            check("n4k3 first window valid", window_valid_out, 1);
            check_win("n4k3 first window", window_out, model_win(4, 3, 0, 0));
         end
         if (i == 15) begin
            check("n4k3 last window valid", window_valid_out, 1);
            check_win("n4k3 last window", window_out, model_win(4, 3, 1, 1));
            check("n4k3 frame_done after pixel 16", frame_done_out, 1);
         end
      end
      send(1'b0, 32'hdead_beef);
      check("n4k3 frame_done one cycle", frame_done_out, 0);
      check("n4k3 window holds", window_out[DW-1:0], 32'd6);
      idle(2);
      verify("n4k3", 4, 1);

      // N=4 K=1: every pixel emerges one cycle later in entry 0
      img = new[16];
      for (int i = 0; i < 16; i++) img[i] = $urandom;
      push_model(4, 1, 1'b0);
      kernel_size_in = 3'd1;
      img_size_in    = 12'd4;
      for (int i = 0; i < 16; i++) begin
         send(1'b1, img[i]);
         check("k1 window valid", window_valid_out, 1);
         check("k1 entry0", window_out[DW-1:0], img[i]);
         check("k1 upper entries zero", window_out[WB-1:DW] == '0, 1);
      end
      idle(3);
      verify("k1", 16, 1);

      for (int t = 0; t < 7; t++) begin
         run_frame(tbl[t].n, tbl[t].k, 1'b0, 0, 1'b0);
         idle(3);
         verify($sformatf("table n%0d k%0d", tbl[t].n, tbl[t].k), tbl[t].exp_windows, 1);
         check($sformatf("table n%0d k%0d cfg_err seen", tbl[t].n, tbl[t].k), (err_cyc - err_ptr) > 0, tbl[t].exp_err);
         check($sformatf("table n%0d k%0d cfg_err cleared", tbl[t].n, tbl[t].k), cfg_err_out, 0);
         err_ptr = err_cyc;
      end

      // back-to-back frames with gaps and mid-frame config churn
      run_frame(5, 3, 1'b0, 30, 1'b1);
      run_frame(5, 3, 1'b0, 30, 1'b1);
      run_frame(5, 3, 1'b0, 0, 1'b1);
      run_frame(5, 3, 1'b0, 0, 1'b1);
      idle(3);
      verify("b2b gaps", 36, 4);
      check("b2b no cfg_err", err_cyc - err_ptr, 0);
      err_ptr = err_cyc;

      // reset after pixel 7 of a 4x4 frame
      kernel_size_in = 3'd3;
      img_size_in    = 12'd4;
      for (int i = 0; i < 7; i++) send(1'b1, $urandom);
      pixel_valid_in = 1'b0;
      rstn = 1'b0;
      #1;
      check("midreset window_valid", window_valid_out, 0);
      check("midreset window_out zero", window_out == '0, 1);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      idle(1);
      run_frame(4, 3, 1'b0, 0, 1'b0);
      idle(3);
      verify("after midreset", 4, 1);

`ifdef SWU_STRIDE2_EN
      run_frame(5, 3, 1'b1, 20, 1'b1);
      idle(3);
      verify("stride2 n5k3", 4, 1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
